stage_sequencer: RTL and testbench
==================================

# stage_sequencer

Parametrised top-level phase sequencer that walks a chain of `NUM_UNITS` processing units (memory, compute, display, …) in fixed order. It replaces the fixed four-state controller. Each unit reports a 2-bit status. The sequencer issues one-cycle start pulses, advances on per-unit completion, and adds a per-stage timeout, error capture, abort, and an optional free-running loop mode. It sits at the top of the datapath and drives the unit enables.

## Interface
Parameters:
- `NUM_UNITS`, default 3: number of chained units; legal range 2..8.
- `TIMEOUT`, default 200: maximum cycles allowed per stage; 0 disables the timeout.
- `TW`, default 8: timeout counter width; requires `TIMEOUT` < 2^`TW`.
- `IW`, default `$clog2(NUM_UNITS)` (minimum 1): unit index width.

Ports:
- `clk`, in, 1: clock; all state changes on the rising edge.
- `rst`, in, 1: reset; synchronous, active-high.
- `status`, in, 2*`NUM_UNITS`: per-unit status; unit k occupies bits [2k+1:2k]. Encoding: 00 idle, 01 ready, 10 done, 11 error.
- `go`, in, 1: level start/acknowledge request.
- `abort`, in, 1: level abort request.
- `loop_en`, in, 1: in DONE, restart the chain automatically.
- `state`, out, 2: 00 INIT, 01 RUN, 10 DONE, 11 ERR.
- `unit_idx`, out, `IW`: index of the active unit.
- `start`, out, `NUM_UNITS`: one-hot, one-cycle start pulse.
- `busy`, out, 1: high while in RUN.
- `done`, out, 1: high while in DONE.
- `error`, out, 1: high while in ERR.
- `err_code`, out, 2: 01 unit error, 10 timeout, 11 abort, 00 none.
- `err_unit`, out, `IW`: unit index active when the error occurred.
- `iter_cnt`, out, 8: number of completed chain passes; wraps 255→0.

## Operation
- **INIT**
  - Condition: `abort` = 1. Next: ERR, `err_code` = 11, `err_unit` = 0.
  - Condition: every unit's status is 01 and `go` = 1. Next: RUN with `unit_idx` = 0.
  - Otherwise: hold.
- **RUN(k)**. Priority order, first match wins:
  1. `abort` → ERR, `err_code` = 11, `err_unit` = k.
  2. status[k] = 11 → ERR, `err_code` = 01, `err_unit` = k.
  3. status[k] = 10:
     - if k < `NUM_UNITS`-1: advance to RUN(k+1);
     - if k = `NUM_UNITS`-1: go to DONE and increment `iter_cnt`.
  4. `TIMEOUT` ≠ 0 and timer = `TIMEOUT`-1 → ERR, `err_code` = 10, `err_unit` = k.
  5. Otherwise: hold and increment the timer.
- RUN ignores status of units other than k. Status 00 or 01 on unit k means keep waiting.
- **DONE**
  - `abort` is ignored.
  - `loop_en` = 1: restart at RUN(0) with a `start` pulse, without checking readiness. This takes priority over `go`.
  - `go` = 1: return to INIT.
  - Otherwise: hold.
- **ERR**
  - Sticky.
  - `go` = 1 and `abort` = 0: return to INIT; `err_code` and `err_unit` clear to 0.
  - Otherwise: hold, with `err_code` and `err_unit` frozen.
- **Timer**
  - Cleared to 0 on every entry into RUN(k), including k→k+1 and a loop restart.
  - Counts only in RUN.
- **`start`**
  - Registered output.
  - `start[k]` = 1 exactly in the first cycle the registered state is RUN(k); 0 in every other cycle.

## Timing
- Reset values: `state` = 00, `unit_idx` = 0, `start` = 0, `busy` = 0, `done` = 0, `error` = 0, `err_code` = 00, `err_unit` = 0, `iter_cnt` = 0, timer = 0.
- Reset priority:
  - `rst` overrides every input in the same edge.
  - Reset mid-RUN returns to INIT with no `start` pulse.
- Inputs are sampled at edge t; the outputs for the new state appear after edge t:
  - `go` sampled with all units ready at edge t → `start[0]` high in cycle t+1.
  - status[k] = 10 sampled at edge t → `start[k+1]` in cycle t+1, so one cycle per stage transition.
- Timeout with `TIMEOUT` = T:
  - Stage entered at edge e, so `start` is high in cycle e.
  - With no completion, `state` = ERR after edge e+T: exactly T RUN cycles.
- Simultaneous events on the same edge:
  - `abort` with status 10 → ERR (abort wins).
  - status 10 with timer at the limit → advance (completion wins).
- `busy`, `done`, `error` are pure decodes of the registered `state`, with no extra latency.

## Test plan
- **Nominal pass.** `NUM_UNITS` = 3, `TIMEOUT` = 0. All units 01, `go` pulse; then units 0, 1, 2 each report 10 two cycles after their `start`. Required:
  - `start` = 001, 010, 100, each a single-cycle pulse;
  - `state` = DONE;
  - `iter_cnt` = 1.
- **Unit error.** During RUN(1), status[1] = 11. Required: `state` = ERR, `err_code` = 01, `err_unit` = 1. Then `go` = 1: INIT with `err_code` = 00.
- **Timeout.** `TIMEOUT` = 4; unit 0 stays at 01 after `start`. Required:
  - ERR after exactly 4 RUN cycles;
  - `err_code` = 10, `err_unit` = 0;
  - a second run with 10 arriving in the 4th cycle advances instead of erroring.
- **Abort priority.** In RUN(2), `abort` = 1 together with status[2] = 10. Required: ERR, `err_code` = 11, `err_unit` = 2, `iter_cnt` unchanged. `abort` in DONE is ignored.
- **Loop mode.** `loop_en` = 1, units completing immediately, 256 passes. Required:
  - `start[0]` in the cycle after each DONE;
  - `iter_cnt` wraps 255→0.
- **Reset mid-run.** `rst` in RUN(1). Required: next cycle `state` = INIT, all outputs at reset values, no `start` pulse.

Source files
------------

// File: rtl/stage_sequencer.sv
// Phase sequencer that walks NUM_UNITS chained processing units in fixed order,
// pulsing start per stage and capturing unit errors, timeouts and aborts.
module stage_sequencer #(
    parameter int NUM_UNITS = 3,
    parameter int TIMEOUT   = 200,
    parameter int TW        = 8,
    parameter int IW        = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2*NUM_UNITS-1:0] status,
    input  logic                   go,
    input  logic                   abort,
    input  logic                   loop_en,
    output logic [1:0]             state,
    output logic [IW-1:0]          unit_idx,
    output logic [NUM_UNITS-1:0]   start,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [1:0]             err_code,
    output logic [IW-1:0]          err_unit,
    output logic [7:0]             iter_cnt
);

    typedef enum logic [1:0] {
        S_INIT = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10,
        S_ERR  = 2'b11
    } state_t;

    localparam logic [1:0] UST_READY = 2'b01;
    localparam logic [1:0] UST_DONE  = 2'b10;
    localparam logic [1:0] UST_ERROR = 2'b11;

    localparam logic [1:0] EC_NONE    = 2'b00;
    localparam logic [1:0] EC_UNIT    = 2'b01;
    localparam logic [1:0] EC_TIMEOUT = 2'b10;
    localparam logic [1:0] EC_ABORT   = 2'b11;

    localparam logic [IW-1:0] LAST_IDX    = IW'(NUM_UNITS - 1);
    localparam bit            TIMEOUT_EN  = (TIMEOUT != 0);
    localparam logic [TW-1:0] TIMER_LIMIT = TIMEOUT_EN ? TW'(TIMEOUT - 1) : '0;

    state_t                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [NUM_UNITS-1:0]   start_q, start_d;
    logic [1:0]             code_q, code_d;
    logic [IW-1:0]          eunit_q, eunit_d;
    logic [7:0]             iter_q, iter_d;

    logic [1:0]             cur_status;
    logic                   all_ready;

    function automatic logic [NUM_UNITS-1:0] onehot(input logic [IW-1:0] i);
        logic [NUM_UNITS-1:0] r;
        r = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            r[k] = (i == IW'(k));
        end
        return r;
    endfunction

    // Status of the active unit, and the "every unit ready" gate used in INIT.
    always_comb begin
        cur_status = 2'b00;
        all_ready  = 1'b1;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (status[2*k +: 2] != UST_READY) all_ready = 1'b0;
            if (idx_q == IW'(k)) cur_status = status[2*k +: 2];
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state_q;
        idx_d   = idx_q;
        timer_d = timer_q;
        start_d = '0;
        code_d  = code_q;
        eunit_d = eunit_q;
        iter_d  = iter_q;

        unique case (state_q)
            S_INIT: begin
                if (abort) begin
                    state_d = S_ERR;
                    code_d  = EC_ABORT;
                    eunit_d = '0;
                end else if (all_ready && go) begin
                    state_d = S_RUN;
                    idx_d   = '0;
                    timer_d = '0;
                    start_d = onehot('0);
                end
            end

            S_RUN: begin
                if (abort) begin
                    state_d = S_ERR;
                    code_d  = EC_ABORT;
                    eunit_d = idx_q;
                end else if (cur_status == UST_ERROR) begin
                    state_d = S_ERR;
                    code_d  = EC_UNIT;
                    eunit_d = idx_q;
                end else if (cur_status == UST_DONE) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                        iter_d  = iter_q + 8'd1;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        timer_d = '0;
                        start_d = onehot(idx_q + IW'(1));
                    end
                end else if (TIMEOUT_EN && timer_q == TIMER_LIMIT) begin
                    state_d = S_ERR;
                    code_d  = EC_TIMEOUT;
                    eunit_d = idx_q;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            S_DONE: begin
                // Loop restart skips the readiness check and beats a pending go.
                if (loop_en) begin
                    state_d = S_RUN;
                    idx_d   = '0;
                    timer_d = '0;
                    start_d = onehot('0);
                end else if (go) begin
                    state_d = S_INIT;
                    idx_d   = '0;
                end
            end

            S_ERR: begin
                if (go && !abort) begin
                    state_d = S_INIT;
                    idx_d   = '0;
                    code_d  = EC_NONE;
                    eunit_d = '0;
                end
            end

            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q <= S_INIT;
            idx_q   <= '0;
            timer_q <= '0;
            start_q <= '0;
            code_q  <= EC_NONE;
            eunit_q <= '0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
            start_q <= start_d;
            code_q  <= code_d;
            eunit_q <= eunit_d;
            iter_q  <= iter_d;
        end
    end

    assign state    = state_q;
    assign unit_idx = idx_q;
    assign start    = start_q;
    assign busy     = (state_q == S_RUN);
    assign done     = (state_q == S_DONE);
    assign error    = (state_q == S_ERR);
    assign err_code = code_q;
    assign err_unit = eunit_q;
    assign iter_cnt = iter_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Scoreboard bench for stage_sequencer: stimulus predicts the transaction-level
// events (stage entries, DONE, ERR, INIT) and a monitor matches what the DUT shows.
module tb_stage_sequencer;

    localparam int N  = 3;
    localparam int T  = 4;
    localparam int IW = 2;

    localparam logic [1:0] ST_INIT = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;
    localparam logic [1:0] ST_ERR  = 2'b11;

    typedef enum int {M_DONE, M_TIMEOUT, M_UERR, M_ABORT} mode_t;

    typedef struct {
        int          cyc;
        logic [31:0] val;
    } ev_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [2*N-1:0] status;
    logic           go, abort, loop_en;
    logic [1:0]     state;
    logic [IW-1:0]  unit_idx;
    logic [N-1:0]   start;
    logic           busy, done, error;
    logic [1:0]     err_code;
    logic [IW-1:0]  err_unit;
    logic [7:0]     iter_cnt;

    int  cyc = 0;
    int  n_checks = 0;
    int  n_errors = 0;
    int  m_iter = 0;
    bit  mon_en = 0;
    ev_t exp_q[$];

    stage_sequencer #(.NUM_UNITS(N), .TIMEOUT(T), .TW(8), .IW(IW)) dut (
        .clk(clk), .rst(rst), .status(status), .go(go), .abort(abort),
        .loop_en(loop_en), .state(state), .unit_idx(unit_idx), .start(start),
        .busy(busy), .done(done), .error(error), .err_code(err_code),
        .err_unit(err_unit), .iter_cnt(iter_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] pack(input logic [1:0] st, input logic [IW-1:0] idx,
                                         input logic [N-1:0] s, input logic [1:0] c,
                                         input logic [IW-1:0] eu, input logic [7:0] it,
                                         input logic [2:0] fl);
        return {10'b0, st, idx, s, c, eu, it, fl};
    endfunction

    // Every expected event is a state change or a start pulse one edge from now.
    task automatic push(input logic [1:0] st, input int k, input int code, input int eu);
        ev_t           e;
        logic [N-1:0]  s;
        logic [IW-1:0] idx;
        s   = (st == ST_RUN) ? N'(1 << k) : '0;
        idx = (st == ST_RUN) ? IW'(k) : '0;
        e.cyc = cyc + 1;
        e.val = pack(st, idx, s, 2'(code), IW'(eu), m_iter[7:0],
                     {st == ST_RUN, st == ST_DONE, st == ST_ERR});
        exp_q.push_back(e);
    endtask

    logic [1:0] prev_state;
    always @(negedge clk) begin
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                ev_t m;
                m = exp_q.pop_front();
                check("missed_event", 32'(cyc), 32'(m.cyc));
            end
            if (state !== prev_state || start !== '0) begin
                logic [31:0] act;
                act = pack(state, (state == ST_RUN) ? unit_idx : '0, start, err_code,
                           err_unit, iter_cnt, {busy, done, error});
                if (exp_q.size() == 0) begin
                    check("unexpected_event", act, 32'hFFFF_FFFF);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    check("event_cycle", 32'(cyc), 32'(e.cyc));
                    check("event_fields", act, e.val);
                end
            end
            prev_state = state;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_unit(input int k, input logic [1:0] v);
        status[2*k +: 2] = v;
    endtask

    task automatic randomize_others(input int k);
        for (int j = 0; j < N; j++) begin
            if (j != k) set_unit(j, 2'($urandom));
        end
    endtask

    task automatic start_chain();
        int noise;
        abort = 0;
        loop_en = 0;
        noise = $urandom_range(0, 2);
        for (int i = 0; i < noise; i++) begin
            int v;
            for (int j = 0; j < N; j++) set_unit(j, 2'b01);
            v = $urandom_range(0, 2);
            set_unit($urandom_range(0, N - 1), (v == 0) ? 2'b00 : 2'(v + 1));
            go = 1'($urandom);
            tick();
        end
        for (int j = 0; j < N; j++) set_unit(j, 2'b01);
        go = 1;
        push(ST_RUN, 0, 0, 0);
        tick();
        go = 0;
    endtask

    // Called in the cycle where start[k] is high.
    task automatic run_stage(input int k, input mode_t m, input int d, output bit ended);
        ended = 0;
        for (int i = 0; i <= T; i++) begin
            randomize_others(k);
            abort = 0;
            loop_en = 0;
            go = 1'($urandom);
            set_unit(k, 2'($urandom_range(0, 1)));
            if (i == d && m == M_DONE) begin
                set_unit(k, 2'b10);
                if (k == N - 1) begin
                    m_iter++;
                    push(ST_DONE, 0, 0, 0);
                end else begin
                    push(ST_RUN, k + 1, 0, 0);
                end
                tick();
                return;
            end
            if (i == d && m == M_UERR) begin
                set_unit(k, 2'b11);
                push(ST_ERR, k, 1, k);
                tick();
                ended = 1;
                return;
            end
            if (i == d && m == M_ABORT) begin
                set_unit(k, 2'b10);
                abort = 1;
                push(ST_ERR, k, 3, k);
                tick();
                abort = 0;
                ended = 1;
                return;
            end
            if (m == M_TIMEOUT && i == T - 1) begin
                push(ST_ERR, k, 2, k);
                tick();
                ended = 1;
                return;
            end
            tick();
        end
    endtask

    task automatic run_chain(input int fail_stage, input mode_t fail_mode, input int fixed_d,
                             output bit errored);
        bit e;
        errored = 0;
        for (int k = 0; k < N; k++) begin
            mode_t m;
            int    d;
            m = (k == fail_stage) ? fail_mode : M_DONE;
            d = (fixed_d >= 0) ? fixed_d : $urandom_range(0, T - 1);
            run_stage(k, m, d, e);
            if (e) begin
                errored = 1;
                return;
            end
        end
    endtask

    task automatic recover_err();
        int n;
        loop_en = 0;
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                go = 1;
                abort = 1;
            end else begin
                go = 0;
                abort = 1'($urandom);
            end
            tick();
        end
        go = 1;
        abort = 0;
        push(ST_INIT, 0, 0, 0);
        tick();
        go = 0;
    endtask

    task automatic done_hold();
        int n;
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) begin
            go = 0;
            loop_en = 0;
            abort = (i == 0) ? 1'b1 : 1'($urandom);
            tick();
        end
        abort = 0;
    endtask

    task automatic go_init();
        loop_en = 0;
        abort = 1'($urandom);
        go = 1;
        push(ST_INIT, 0, 0, 0);
        tick();
        go = 0;
        abort = 0;
    endtask

    task automatic loop_restart();
        loop_en = 1;
        go = 1'($urandom);
        abort = 1'($urandom);
        for (int j = 0; j < N; j++) set_unit(j, 2'($urandom));
        push(ST_RUN, 0, 0, 0);
        tick();
        loop_en = 0;
        go = 0;
        abort = 0;
    endtask

    task automatic init_abort();
        abort = 1;
        go = 1'($urandom);
        push(ST_ERR, 0, 3, 0);
        tick();
        abort = 0;
        recover_err();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"},    32'(state),    32'(0));
        check({tag, "_unit_idx"}, 32'(unit_idx), 32'(0));
        check({tag, "_start"},    32'(start),    32'(0));
        check({tag, "_flags"},    32'({busy, done, error}), 32'(0));
        check({tag, "_err_code"}, 32'(err_code), 32'(0));
        check({tag, "_err_unit"}, 32'(err_unit), 32'(0));
        check({tag, "_iter_cnt"}, 32'(iter_cnt), 32'(0));
    endtask

    initial begin
        bit err;
        rst = 1;
        go = 0;
        abort = 0;
        loop_en = 0;
        status = '0;
        tick();
        tick();
        rst = 0;
        check_reset_outputs("reset");
        prev_state = state;
        mon_en = 1;

        // Nominal pass: each unit completes two cycles after its start.
        start_chain();
        run_chain(-1, M_DONE, 2, err);
        check("nominal_iter", 32'(iter_cnt), 32'(1));
        done_hold();
        go_init();

        // Unit error in stage 1, then recovery.
        start_chain();
        run_chain(1, M_UERR, 1, err);
        recover_err();
        check("recover_err_code", 32'(err_code), 32'(0));

        // Timeout in stage 0, then completion landing on the last allowed cycle.
        start_chain();
        run_chain(0, M_TIMEOUT, 0, err);
        recover_err();
        start_chain();
        run_chain(-1, M_DONE, T - 1, err);
        go_init();

        // Abort together with completion in the last stage; abort in DONE ignored.
        start_chain();
        run_chain(N - 1, M_ABORT, 1, err);
        recover_err();
        start_chain();
        run_chain(-1, M_DONE, -1, err);
        done_hold();
        go_init();

        init_abort();

        // Loop mode with immediate completion across the iter_cnt wrap.
        start_chain();
        for (int p = 0; p < 256; p++) begin
            run_chain(-1, M_DONE, 0, err);
            loop_restart();
        end
        run_chain(-1, M_DONE, 0, err);
        check("loop_iter_wrap", 32'(iter_cnt), 32'(m_iter % 256));
        go_init();

        // Randomized mix of passes, failures and restarts.
        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(0, 9) == 0) begin
                init_abort();
            end else begin
                int    fs;
                mode_t fm;
                start_chain();
                fs = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, N - 1)) : -1;
                fm = mode_t'($urandom_range(1, 3));
                run_chain(fs, fm, -1, err);
                if (err) begin
                    recover_err();
                end else begin
                    done_hold();
                    if ($urandom_range(0, 1) == 1) begin
                        loop_restart();
                        run_chain(-1, M_DONE, -1, err);
                        done_hold();
                    end
                    go_init();
                end
            end
        end

        // Reset while in RUN(1).
        start_chain();
        run_stage(0, M_DONE, 1, err);
        rst = 1;
        go = 1;
        m_iter = 0;
        push(ST_INIT, 0, 0, 0);
        tick();
        rst = 0;
        go = 0;
        check_reset_outputs("midrun_reset");
        tick();
        tick();
        start_chain();
        run_chain(-1, M_DONE, -1, err);
        go_init();

        tick();
        tick();
        tick();
        check("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
